// File: rtl/fb_line_prefetch_pkg.sv
// Shared types for the framebuffer line prefetcher: the RGB565 pixel word
// and the encoding of the row-fetch state machine.
package fb_line_prefetch_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/fb_line_ram.sv
// One line buffer: simple dual-port RAM, synchronous write, registered read.
// The read register only updates on rd_en so the display data holds between reads.
module fb_line_ram
  import fb_line_prefetch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rgb565_t       wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output rgb565_t       rd_data
);

  rgb565_t mem [DEPTH];

  // Fetch side writes one word per returned memory response.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Display side read, registered; holds its value when not reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fb_line_prefetch.sv
// Serves display reads from a ping-pong pair of line buffers and refills the
// idle ("next") buffer one row at a time from a slow, variable-latency memory.
module fb_line_prefetch
  import fb_line_prefetch_pkg::*;
#(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 64,
  parameter int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                         pixel_clk,
  input  logic                         rst_n,
  input  logic [$clog2(FB_WIDTH)-1:0]  fb_read_x,
  input  logic [$clog2(FB_HEIGHT)-1:0] fb_read_y,
  input  logic                         fb_read_en,
  output rgb565_t                      fb_read_data,
  output logic                         fb_read_valid,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ready,
  input  logic [15:0]                  mem_rdata,
  input  logic                         mem_rvalid,
  output logic                         underrun,
  output logic                         fetch_busy
);

  localparam int COL_W = $clog2(FB_WIDTH);
  localparam int ROW_W = $clog2(FB_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FB_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FB_HEIGHT - 1);

  // Display-side state
  logic [ROW_W-1:0] cur_row_reg;
  logic [ROW_W-1:0] nxt_row_reg;
  logic             cur_valid_reg;
  logic             nxt_valid_reg;
  logic             buf_sel_reg;   // which RAM currently holds cur_row
  logic             out_sel_reg;   // which RAM's read register drives fb_read_data
  logic             valid_reg;
  logic             underrun_reg;

  // Fetch-side state
  fetch_state_t     state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] fetch_row_reg; // row latched at fetch start keeps mem_addr stable
  logic             discard_reg;   // outstanding fetch belongs to an abandoned row

  logic    hit, swap, pend, resync;
  logic    start, rsp, wr_en, fill_done;
  rgb565_t wr_word;
  rgb565_t rd_word [2];

  // Read classification; a hit on the current row takes priority.
  assign hit    = fb_read_en && cur_valid_reg && (fb_read_y == cur_row_reg);
  assign swap   = fb_read_en && !hit && (fb_read_y == nxt_row_reg) && nxt_valid_reg;
  assign pend   = fb_read_en && !hit && (fb_read_y == nxt_row_reg) && !nxt_valid_reg;
  assign resync = fb_read_en && !hit && (fb_read_y != nxt_row_reg);

  assign start     = (state_reg == ST_IDLE) && !nxt_valid_reg && !discard_reg;
  assign rsp       = (state_reg == ST_WAIT) && mem_rvalid;
  assign wr_en     = rsp && !discard_reg;
  assign fill_done = wr_en && (col_reg == COL_LAST) && !resync;
  assign wr_word   = rgb565_t'(mem_rdata);

  assign fb_read_data  = rd_word[out_sel_reg];
  assign fb_read_valid = valid_reg;
  assign underrun      = underrun_reg;
  assign mem_req       = (state_reg == ST_REQ);
  assign fetch_busy    = (state_reg != ST_IDLE);
  assign mem_addr      = ADDR_W'(fetch_row_reg) * ADDR_W'(FB_WIDTH) + ADDR_W'(col_reg);

  // Display-side bookkeeping: buffer swap, resync and sticky underrun.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row_reg   <= ROW_LAST;
      nxt_row_reg   <= '0;
      cur_valid_reg <= 1'b0;
      nxt_valid_reg <= 1'b0;
      buf_sel_reg   <= 1'b0;
      out_sel_reg   <= 1'b0;
      valid_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      valid_reg <= hit || swap;
      if (pend || resync) underrun_reg <= 1'b1;
      if (hit) out_sel_reg <= buf_sel_reg;
      if (swap) begin
        out_sel_reg   <= ~buf_sel_reg;
        buf_sel_reg   <= ~buf_sel_reg;
        cur_row_reg   <= nxt_row_reg;
        cur_valid_reg <= 1'b1;
        nxt_row_reg   <= (nxt_row_reg == ROW_LAST) ? '0 : nxt_row_reg + ROW_W'(1);
        nxt_valid_reg <= 1'b0;
      end else if (resync) begin
        cur_valid_reg <= 1'b0;
        nxt_row_reg   <= fb_read_y;
        nxt_valid_reg <= 1'b0;
      end else if (fill_done) begin
        nxt_valid_reg <= 1'b1;
      end
    end
  end

  // Row fetch: one outstanding request at a time, column by column.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      col_reg       <= '0;
      fetch_row_reg <= '0;
      discard_reg   <= 1'b0;
    end else begin
      // A resync abandons the running fetch unless its final response lands now.
      if (resync && (start || state_reg == ST_REQ || (state_reg == ST_WAIT && !mem_rvalid)))
        discard_reg <= 1'b1;
      else if (rsp)
        discard_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_REQ;
            col_reg       <= '0;
            fetch_row_reg <= nxt_row_reg;
          end
        end
        ST_REQ: begin
          if (mem_ready) state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (discard_reg || resync || col_reg == COL_LAST) begin
              state_reg <= ST_IDLE;
            end else begin
              col_reg   <= col_reg + COL_W'(1);
              state_reg <= ST_REQ;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Two line buffers; fetch writes the one not selected as current.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    logic is_cur;
    assign is_cur = (buf_sel_reg == 1'(gi));
    fb_line_ram #(.DEPTH(FB_WIDTH)) u_ram (
      .clk     (pixel_clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en && !is_cur),
      .wr_addr (col_reg),
      .wr_data (wr_word),
      .rd_en   ((hit && is_cur) || (swap && !is_cur)),
      .rd_addr (fb_read_x),
      .rd_data (rd_word[gi])
    );
  end

endmodule
